// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC controller: owns the PC and the instruction-memory request,
// and merges sequential fetch, EX redirects, stalls and halts.
module pc_sequencer #(
    parameter int unsigned    N            = 64,
    parameter logic [N-1:0]   RESET_VECTOR = '0,
    parameter int unsigned    INC          = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         halt_i,
    input  logic         redirect_valid_i,
    input  logic [N-1:0] redirect_target_i,
    output logic         imem_req_o,
    output logic [N-1:0] imem_addr_o,
    input  logic         imem_ready_i,
    output logic [N-1:0] pc_o,
    output logic         if_valid_o,
    output logic [N-1:0] if_pc_o,
    output logic         flush_o,
    output logic         fault_o,
    output logic         halted_o
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] pc_nxt;
    logic [N-1:0] if_pc_nxt;
    logic         if_valid_nxt;
    logic         flush_nxt;
    logic         accept;

    assign imem_addr_o = pc_o;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc_o       <= RESET_VECTOR;
            if_pc_o    <= '0;
            if_valid_o <= 1'b0;
            flush_o    <= 1'b0;
            fault_o    <= 1'b0;
            halted_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc_o       <= pc_nxt;
            if_pc_o    <= if_pc_nxt;
            if_valid_o <= if_valid_nxt;
            flush_o    <= flush_nxt;
            fault_o    <= (state_nxt == FAULT);
            halted_o   <= (state_nxt == HALTED);
        end
    end

    // Next-state logic; priority is redirect > halt > stall > sequential
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_o;
        if_pc_nxt    = if_pc_o;
        if_valid_nxt = 1'b0;
        flush_nxt    = 1'b0;
        imem_req_o   = 1'b0;
        accept       = 1'b0;

        case (state)
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                if (redirect_valid_i) begin
                    flush_nxt = 1'b1;
                    if (redirect_target_i[1:0] == 2'b00) begin
                        pc_nxt    = redirect_target_i;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = FAULT;
                    end
                end else if (state == BOOT) begin
                    state_nxt = FETCH;
                end else if (state == FETCH) begin
                    if (halt_i) begin
                        state_nxt = HALTED;
                    end else begin
                        imem_req_o = !stall_i;
                        accept     = imem_req_o && imem_ready_i;
                        if (accept) begin
                            pc_nxt       = pc_o + N'(INC);
                            if_pc_nxt    = pc_o;
                            if_valid_nxt = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic,
// compared each cycle against a flag-based behavioural model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        halt_i;
    logic        redirect_valid_i;
    logic [63:0] redirect_target_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_ready_i;
    logic [63:0] pc_o;
    logic        if_valid_o;
    logic [63:0] if_pc_o;
    logic        flush_o;
    logic        fault_o;
    logic        halted_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: plain flags rather than a state machine
    logic        m_booting;
    logic        m_halted;
    logic        m_faulted;
    logic [63:0] m_pc;
    logic        m_ifv;
    logic [63:0] m_ifpc;
    logic        m_flush;

    pc_sequencer #(.N(64), .RESET_VECTOR(64'h0), .INC(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .halt_i            (halt_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_ready_i      (imem_ready_i),
        .pc_o              (pc_o),
        .if_valid_o        (if_valid_o),
        .if_pc_o           (if_pc_o),
        .flush_o           (flush_o),
        .fault_o           (fault_o),
        .halted_o          (halted_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_booting = 1'b1;
        m_halted  = 1'b0;
        m_faulted = 1'b0;
        m_pc      = 64'h0;
        m_ifv     = 1'b0;
        m_ifpc    = 64'h0;
        m_flush   = 1'b0;
    endtask

    task automatic check_regs();
        check_val("pc",       pc_o,                m_pc);
        check_val("if_valid", 64'(if_valid_o),     64'(m_ifv));
        check_val("if_pc",    if_pc_o,             m_ifpc);
        check_val("flush",    64'(flush_o),        64'(m_flush));
        check_val("fault",    64'(fault_o),        64'(m_faulted));
        check_val("halted",   64'(halted_o),       64'(m_halted));
    endtask

    // Called at posedge+1; asynchronous reset takes effect without a clock edge
    task automatic do_reset();
        rst = 1'b1;
        stall_i = 1'b0; halt_i = 1'b0; redirect_valid_i = 1'b0;
        redirect_target_i = 64'h0; imem_ready_i = 1'b0;
        #1;
        model_reset();
        check_regs();
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check request, advance model, check registers
    task automatic step(input logic st, input logic ht, input logic rv,
                        input logic [63:0] rt, input logic rdy);
        logic exp_req;
        logic acc;
        stall_i = st; halt_i = ht; redirect_valid_i = rv;
        redirect_target_i = rt; imem_ready_i = rdy;
        #1;
        exp_req = !m_booting && !m_halted && !m_faulted && !st && !ht && !rv;
        check_val("imem_req",  64'(imem_req_o), 64'(exp_req));
        check_val("imem_addr", imem_addr_o,     m_pc);
        @(posedge clk);
        m_flush = 1'b0;
        m_ifv   = 1'b0;
        if (m_faulted) begin
            // nothing changes until reset
        end else if (rv) begin
            m_flush = 1'b1;
            if (rt % 4 == 0) begin
                m_pc      = rt;
                m_booting = 1'b0;
                m_halted  = 1'b0;
            end else begin
                m_faulted = 1'b1;
                m_booting = 1'b0;
                m_halted  = 1'b0;
            end
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_halted) begin
            // wait for a redirect
        end else if (ht) begin
            m_halted = 1'b1;
        end else begin
            acc = !st && rdy;
            if (acc) begin
                m_ifpc = m_pc;
                m_pc   = m_pc + 64'd4;
                m_ifv  = 1'b1;
            end
        end
        #1;
        check_regs();
    endtask

    initial begin
        rst = 1'b1;
        stall_i = 1'b0; halt_i = 1'b0; redirect_valid_i = 1'b0;
        redirect_target_i = 64'h0; imem_ready_i = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Boot cycle, then three sequential accepts
        step(0, 0, 0, 64'h0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 64'h0, 1);
        check_val("pc_after_3", pc_o, 64'hC);
        check_val("last_if_pc", if_pc_o, 64'h8);

        // Stall for two cycles at 0x8 with memory ready
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 64'h0, 1);
        check_val("pc_pre_stall", pc_o, 64'h8);
        step(1, 0, 0, 64'h0, 1);
        step(1, 0, 0, 64'h0, 1);
        check_val("pc_stalled", pc_o, 64'h8);
        step(0, 0, 0, 64'h0, 1);
        check_val("resume_if_pc", if_pc_o, 64'h8);

        // Redirect while a request is pending
        step(0, 0, 0, 64'h0, 0);
        step(0, 0, 1, 64'h100, 0);
        check_val("redir_flush", 64'(flush_o), 64'h1);
        check_val("redir_pc", pc_o, 64'h100);
        step(0, 0, 0, 64'h0, 1);
        check_val("redir_if_pc", if_pc_o, 64'h100);
        check_val("flush_one_shot", 64'(flush_o), 64'h0);

        // Misaligned redirect faults; later redirects ignored; reset clears
        step(0, 0, 1, 64'h102, 1);
        check_val("fault_set", 64'(fault_o), 64'h1);
        step(0, 0, 1, 64'h200, 1);
        step(0, 0, 0, 64'h0, 1);
        step(1, 1, 0, 64'h0, 1);
        check_val("fault_pc_hold", pc_o, 64'h104);
        do_reset();
        check_val("fault_cleared", 64'(fault_o), 64'h0);

        // Halt at 0x20, then redirect out of HALTED
        step(0, 0, 0, 64'h0, 1);
        step(0, 0, 1, 64'h20, 0);
        step(0, 1, 0, 64'h0, 1);
        check_val("halt_pc", pc_o, 64'h20);
        check_val("halted", 64'(halted_o), 64'h1);
        step(0, 0, 0, 64'h0, 1);
        step(1, 0, 1, 64'h40, 1);
        check_val("unhalt", 64'(halted_o), 64'h0);
        step(0, 0, 0, 64'h0, 1);
        check_val("unhalt_if_pc", if_pc_o, 64'h40);

        // Wrap at the top of the address space; redirect beats halt and stall
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        step(0, 0, 0, 64'h0, 1);
        check_val("wrap_pc", pc_o, 64'h0);
        step(1, 1, 1, 64'h300, 1);
        check_val("prio_pc", pc_o, 64'h300);
        check_val("prio_halted", 64'(halted_o), 64'h0);

        // Reset mid-operation drops the in-flight fetch
        step(0, 0, 0, 64'h0, 1);
        do_reset();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        st, ht, rv, rdy;
            logic [63:0] rt;
            st  = ($urandom_range(0, 3) == 0);
            ht  = ($urandom_range(0, 24) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rt  = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 7) != 0) rt[1:0] = 2'b00;
            if ($urandom_range(0, 59) == 0 || (m_faulted && $urandom_range(0, 9) == 0))
                do_reset();
            else
                step(st, ht, rv, rt, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the RISC-V pipeline fetch stage.
- Owns the program counter register and the instruction-memory fetch handshake.
- Merges sequential increment, EX-stage branch/jump redirects, hazard-unit stalls and halt requests.
- Produces the fetched-instruction valid/PC pair for IF/ID and a flush pulse for the younger pipeline registers.

Parameters:
N, 64, PC and address width in bits.
RESET_VECTOR, 64'h0, PC value loaded on reset.
INC, 4, sequential PC increment in bytes.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
stall_i  input  1  hazard unit: hold the PC; no new fetch accepted.
halt_i  input  1  single-cycle pulse: ecall/ebreak retired; stop fetching.
redirect_valid_i  input  1  single-cycle pulse: taken branch or jump resolved in EX.
redirect_target_i  input  N  redirect destination address.
imem_req_o  output  1  fetch request to instruction memory.
imem_addr_o  output  N  fetch address; always equal to pc_o.
imem_ready_i  input  1  memory accepts the request and returns data this cycle.
pc_o  output  N  current PC register.
if_valid_o  output  1  registered: the instruction accepted last cycle is valid.
if_pc_o  output  N  registered: PC of the instruction flagged by if_valid_o.
flush_o  output  1  registered single-cycle pulse: flush IF/ID and ID/EX.
fault_o  output  1  sticky misaligned-redirect fault.
halted_o  output  1  high while in the HALTED state.

Behaviour:
- Reset (asynchronous on rst=1):
  - pc_o=RESET_VECTOR; if_pc_o=0.
  - if_valid_o=0, flush_o=0, fault_o=0, halted_o=0.
  - state=BOOT.
- States: BOOT, FETCH, HALTED, FAULT.
- BOOT: one idle cycle after rst deasserts, imem_req_o=0; then go to FETCH.
- FETCH:
  - imem_req_o = !stall_i && !redirect_valid_i.
  - accept = imem_req_o && imem_ready_i.
  - On accept: pc_o <= pc_o+INC, wrapping modulo 2^N. Next cycle, if_valid_o=1 and if_pc_o=old pc_o.
  - No accept: pc_o holds and if_valid_o=0 next cycle. imem_addr_o stays stable while the request is pending.
- Priority within a cycle: redirect > halt > stall > sequential.
- Redirect (any state except FAULT):
  - If redirect_target_i[1:0]==0: pc_o <= target; flush_o=1 and if_valid_o=0 next cycle; state -> FETCH, including from HALTED.
  - If redirect_target_i[1:0]!=0: state -> FAULT; fault_o=1; flush_o=1 next cycle; pc_o holds.
  - A pending, unaccepted request is withdrawn in the redirect cycle; the memory must tolerate this.
- Halt in FETCH with no redirect:
  - State -> HALTED; imem_req_o=0.
  - An accept coinciding with halt_i is suppressed: pc_o holds, if_valid_o=0.
- HALTED: halted_o=1; imem_req_o=0; pc_o holds; only a redirect exits.
- FAULT: imem_req_o=0; fault_o=1 sticky; all inputs ignored until rst.
- Stall concurrent with imem_ready_i: no accept. Stall has no effect on flush_o.
- flush_o is never asserted for more than one consecutive cycle per redirect pulse.
- Reset mid-operation: outputs go to reset values immediately; any in-flight fetch is dropped.

Test Plan:
- Reset, then imem_ready_i=1 held -> BOOT cycle with req=0; if_pc_o sequence 0x0,0x4,0x8; pc_o=0xC after 3 accepts.
- Stall for 2 cycles at pc=0x8 with ready=1 -> imem_req_o=0, pc_o stays 0x8, if_valid_o=0 for 2 cycles, then resumes at 0x8.
- Redirect to 0x100 while a request is pending (ready=0) -> next cycle flush_o=1, if_valid_o=0, pc_o=0x100; following accept yields if_pc_o=0x100.
- Redirect to 0x102 -> fault_o=1, imem_req_o=0 permanently; further redirects ignored; rst clears fault_o.
- halt_i with ready=1 at pc=0x20 -> no accept, halted_o=1, pc_o=0x20; redirect to 0x40 -> halted_o=0, flush_o=1, fetch at 0x40.
- pc_o=2^N-4, accept -> pc_o wraps to 0x0; halt_i, redirect_valid_i and stall_i in the same cycle -> redirect wins.
